bus_arbiter_rr: RTL

//   Round-robin arbiter that shares one 16-bit send/ack target (memory or peripheral) among
//   N_REQ processor FSMs. Each requester uses the 2-bit send/ack four-phase handshake.
//   The arbiter latches the winner's command and data and drives the shared target port.
//   It returns the target's ack to the winner only, then waits for that requester to

---
 rtl/arb_pkg.sv | 44 ++++
 rtl/rr_picker.sv | 42 ++++
 rtl/bus_arbiter_rr.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types for the round-robin bus arbiter: send/ack encodings, the
//   arbiter FSM states and the default grant-index width.
//   Helpers classify send/ack codes so the reserved values (11) behave as idle
//   on the request side and as "no ack" on the target side.
// -----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_WR   = 2'b01,
      CMD_RD   = 2'b10,
      CMD_RSV  = 2'b11
   } cmd_t;

   typedef enum logic [1:0] {
      ACK_NONE = 2'b00,
      ACK_DONE = 2'b01,
      ACK_ERR  = 2'b10,
      ACK_RSV  = 2'b11
   } ack_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_RESP  = 2'b10,
      ST_DRAIN = 2'b11
   } state_t;

   localparam int N_REQ_DEF = 4;
   localparam int ID_W      = $clog2(N_REQ_DEF);

   // Only write and read are grantable; reserved is treated as idle.
   function automatic logic is_valid_cmd(input logic [1:0] cmd);
      return (cmd == CMD_WR) || (cmd == CMD_RD);
   endfunction

   // Only done and error terminate ISSUE; reserved is treated as none.
   function automatic logic is_valid_ack(input logic [1:0] ack);
      return (ack == ACK_DONE) || (ack == ACK_ERR);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. The winner is the first asserted bit
//   of i_valid strictly after i_rr_ptr, searching upward with wrap, so the
//   previous owner (i_rr_ptr) has the lowest priority.
// Ports
//   i_valid     in  N_REQ  request-valid vector
//   i_rr_ptr    in  ID_W   index of the last owner
//   o_winner    out ID_W   selected index (0 when nothing is valid)
//   o_any_valid out 1      at least one request is valid
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [ID_W-1:0]  i_rr_ptr,
   output logic [ID_W-1:0]  o_winner,
   output logic             o_any_valid
);

   int w_dist;
   int w_best;

   // Rank every index by its distance after the pointer (0 = next in line)
   // and keep the closest valid one.
   always_comb begin
      o_winner = '0;
      w_best   = N_REQ;
      w_dist   = 0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = (j + N_REQ - 1 - int'(i_rr_ptr)) % N_REQ;
         if (i_valid[j] && (w_dist < w_best)) begin
            w_best   = w_dist;
            o_winner = ID_W'(j);
         end
      end
   end

   assign o_any_valid = |i_valid;

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter sharing one send/ack target among N_REQ requesters
//   using the 2-bit four-phase send/ack handshake. The winner's command and
//   data are latched and driven to the target; the target's ack goes back to
//   the winner only and is held until that requester releases send.
//   FSM: IDLE -> ISSUE -> RESP -> DRAIN -> IDLE. All outputs are registered.
// Configuration
//   ARB_TIMEOUT_EN : when defined, ISSUE is abandoned with an error ack after
//                    TIMEOUT cycles without a target ack. Undefined: ISSUE
//                    waits indefinitely and no counter exists.
// Ports
//   clk       in  1             clock (posedge)
//   rst       in  1             synchronous active-high reset
//   req_send  in  2*N_REQ       per-requester command, slice i = [2i+1:2i]
//   req_dado  in  DATA_W*N_REQ  per-requester data, slice i = [DATA_W*i +: DATA_W]
//   req_ack   out 2*N_REQ       per-requester ack (non-owners always 00)
//   tgt_send  out 2             command to shared target
//   tgt_dado  out DATA_W        data to shared target
//   tgt_ack   in  2             ack from shared target
//   grant_id  out clog2(N_REQ)  current or last owner
//   busy      out 1             FSM not in IDLE
// -----------------------------------------------------------------------------
module bus_arbiter_rr
   import arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*N_REQ-1:0]        req_send,
   input  logic [DATA_W*N_REQ-1:0]   req_dado,
   output logic [2*N_REQ-1:0]        req_ack,
   output logic [1:0]                tgt_send,
   output logic [DATA_W-1:0]         tgt_dado,
   input  logic [1:0]                tgt_ack,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      busy
);

   localparam int GW = $clog2(N_REQ);

   if ((N_REQ < 2) || (N_REQ > 8) || (TIMEOUT < 1)) begin : g_bad_param
      $error("bus_arbiter_rr: N_REQ must be 2..8 and TIMEOUT >= 1");
   end

   state_t               r_state, w_state_nxt;
   logic [GW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
   logic [GW-1:0]        r_grant_id, w_grant_id_nxt;
   logic [1:0]           r_tgt_send, w_tgt_send_nxt;
   logic [DATA_W-1:0]    r_tgt_dado, w_tgt_dado_nxt;
   logic [2*N_REQ-1:0]   r_req_ack, w_req_ack_nxt;
   logic                 r_busy, w_busy_nxt;

   logic [N_REQ-1:0]     w_valid;
   logic [GW-1:0]        w_winner;
   logic                 w_any_valid;
   logic [1:0]           w_win_cmd;
   logic [DATA_W-1:0]    w_win_dado;
   logic [1:0]           w_own_send;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]        r_tmo_cnt, w_tmo_cnt_nxt;
   logic                 w_tmo_hit;
   // Counter value k means this is ISSUE cycle k+1, so the last allowed
   // cycle is TIMEOUT-1.
   assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT - 1));
`endif

   // Request decode, winner mux and current-owner send lookup.
   always_comb begin
      w_valid    = '0;
      w_win_cmd  = CMD_IDLE;
      w_win_dado = '0;
      w_own_send = CMD_IDLE;
      for (int i = 0; i < N_REQ; i++) begin
         w_valid[i] = is_valid_cmd(req_send[2*i +: 2]);
         if (w_winner == GW'(i)) begin
            w_win_cmd  = req_send[2*i +: 2];
            w_win_dado = req_dado[DATA_W*i +: DATA_W];
         end
         if (r_grant_id == GW'(i)) begin
            w_own_send = req_send[2*i +: 2];
         end
      end
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (GW)
   ) u_picker (
      .i_valid     (w_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_winner    (w_winner),
      .o_any_valid (w_any_valid)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_grant_id_nxt = r_grant_id;
      w_tgt_send_nxt = r_tgt_send;
      w_tgt_dado_nxt = r_tgt_dado;
      w_req_ack_nxt  = r_req_ack;
      w_busy_nxt     = r_busy;
`ifdef ARB_TIMEOUT_EN
      w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any_valid) begin
               w_state_nxt    = ST_ISSUE;
               w_grant_id_nxt = w_winner;
               w_tgt_send_nxt = w_win_cmd;
               w_tgt_dado_nxt = w_win_dado;
               w_busy_nxt     = 1'b1;
`ifdef ARB_TIMEOUT_EN
               w_tmo_cnt_nxt  = '0;
`endif
            end
         end
         ST_ISSUE: begin
            if (is_valid_ack(tgt_ack)) begin
               w_state_nxt    = ST_RESP;
               w_tgt_send_nxt = CMD_IDLE;
               for (int i = 0; i < N_REQ; i++) begin
                  w_req_ack_nxt[2*i +: 2] = (r_grant_id == GW'(i)) ? tgt_ack : ACK_NONE;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_state_nxt    = ST_RESP;
               w_tgt_send_nxt = CMD_IDLE;
               for (int i = 0; i < N_REQ; i++) begin
                  w_req_ack_nxt[2*i +: 2] = (r_grant_id == GW'(i)) ? ACK_ERR : ACK_NONE;
               end
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Ack stays up until the owner completes the four-phase release.
            if (w_own_send == CMD_IDLE) begin
               w_state_nxt   = ST_IDLE;
               w_req_ack_nxt = '0;
               w_rr_ptr_nxt  = r_grant_id;
               w_busy_nxt    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= GW'(N_REQ - 1);
         r_grant_id <= '0;
         r_tgt_send <= CMD_IDLE;
         r_tgt_dado <= '0;
         r_req_ack  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_tgt_send <= w_tgt_send_nxt;
         r_tgt_dado <= w_tgt_dado_nxt;
         r_req_ack  <= w_req_ack_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= w_tmo_cnt_nxt;
      end
   end
`endif

   assign req_ack  = r_req_ack;
   assign tgt_send = r_tgt_send;
   assign tgt_dado = r_tgt_dado;
   assign grant_id = r_grant_id;
   assign busy     = r_busy;

endmodule
